// File: rtl/rv32_pkg.sv
// Shared rv32 fetch-side definitions: FSM state encoding, datapath widths
// and the default reset / trap vectors.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_INC        = 32'h0000_0004;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [XLEN-1:0] RESET_VECTOR  = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VECTOR   = 32'h0000_0100;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap, then redirect, then sequential advance,
// otherwise hold. Purely combinational.
// Build option: PC_MISALIGN_TRAP_EN turns a misaligned redirect target into
// a trap-vector load and flags it on o_misalign.
module pc_next_sel
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] P_TRAP_VECTOR = TRAP_VECTOR
)(
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_trap_req,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_redirect
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            o_misalign
`endif
);

    // Select the next pc; any non-sequential source raises o_redirect.
    always_comb begin
        o_next_pc  = i_pc;
        o_redirect = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        o_misalign = 1'b0;
`endif
        if (i_trap_req) begin
            o_next_pc  = P_TRAP_VECTOR;
            o_redirect = 1'b1;
        end else if (i_redirect_valid) begin
            o_redirect = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if ((i_redirect_pc & ~PC_ALIGN_MASK) != '0) begin
                o_next_pc  = P_TRAP_VECTOR;
                o_misalign = 1'b1;
            end else begin
                o_next_pc  = i_redirect_pc;
            end
`else
            // Low bits are simply dropped: targets are always word aligned.
            o_next_pc = i_redirect_pc & PC_ALIGN_MASK;
`endif
        end else if (i_advance) begin
            o_next_pc = i_pc + PC_INC;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the pc, issues one instruction fetch at a time,
// holds the returned instruction for decode and applies redirects / traps.
// Responses belonging to a request made stale by a redirect are drained.
// Build option: PC_MISALIGN_TRAP_EN adds the misalign_err output.
//
// state | meaning
// FETCH | if_req high at pc, waiting for grant
// WAIT  | request granted, waiting for its response
// HOLD  | instruction held on inst_*, waiting for decode
// DRAIN | outstanding response is stale, discard it when it arrives
module pc_sequencer
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] P_RESET_VECTOR = RESET_VECTOR,
    parameter logic [XLEN-1:0] P_TRAP_VECTOR  = TRAP_VECTOR
)(
    input  logic            clk,
    input  logic            rst_n,
    output logic            if_req,
    output logic [XLEN-1:0] if_addr,
    input  logic            if_gnt,
    input  logic            if_rvalid,
    input  logic [ILEN-1:0] if_rdata,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_req
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign_err
`endif
);

    seq_state_t      r_state;
    seq_state_t      w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect;
    logic            w_advance;
    logic [ILEN-1:0] r_inst_data;
    logic [XLEN-1:0] r_inst_pc;
`ifdef PC_MISALIGN_TRAP_EN
    logic            w_misalign;
    logic            r_misalign;
`endif

    assign w_advance = (r_state == HOLD) && inst_ready;

    pc_next_sel #(
        .P_TRAP_VECTOR (P_TRAP_VECTOR)
    ) u_pc_next_sel (
        .i_pc             (r_pc),
        .i_trap_req       (trap_req),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_advance        (w_advance),
        .o_next_pc        (w_next_pc),
        .o_redirect       (w_redirect)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .o_misalign       (w_misalign)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_state_next;
    end

    // Next-state: a redirect with a request still in flight goes to DRAIN so
    // that the stale response is never presented to decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (if_gnt) w_state_next = w_redirect ? DRAIN : WAIT;
            end
            WAIT: begin
                if (if_rvalid)       w_state_next = w_redirect ? FETCH : HOLD;
                else if (w_redirect) w_state_next = DRAIN;
            end
            HOLD: begin
                if (w_redirect || inst_ready) w_state_next = FETCH;
            end
            DRAIN: begin
                if (if_rvalid) w_state_next = FETCH;
            end
            default: w_state_next = FETCH;
        endcase
    end

    // Outputs: the request is masked during reset because FETCH is the
    // reset state.
    always_comb begin
        if_req     = (r_state == FETCH) && rst_n;
        inst_valid = (r_state == HOLD);
    end

    // Program counter; the mux already folds in hold / advance / redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pc <= P_RESET_VECTOR;
        else        r_pc <= w_next_pc;
    end

    // Capture the response unless a redirect makes it stale in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_data <= '0;
            r_inst_pc   <= '0;
        end else if ((r_state == WAIT) && if_rvalid && !w_redirect) begin
            r_inst_data <= if_rdata;
            r_inst_pc   <= r_pc;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // One-cycle flag aligned with the trap-vector load of the pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_misalign <= 1'b0;
        else        r_misalign <= w_misalign;
    end

    assign misalign_err = r_misalign;
`endif

    assign if_addr   = r_pc;
    assign inst_data = r_inst_data;
    assign inst_pc   = r_inst_pc;

endmodule
